// File: rtl/plot_pkg.sv
// plot_pkg: shared screen geometry defaults, the buffered pixel record, the
// output FSM state type and the coordinate-to-address mapping.
// Imported by plot_fifo users and plot_writer.
package plot_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  // Must hold SCREEN_W*SCREEN_H-1 (19199 for the default screen).
  localparam int ADDR_W       = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } pix_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  // y*w + x at ADDR_W bits. The default 160-column screen is y*128 + y*32 + x,
  // so it needs only shifts and adds; other widths fall back to a multiply.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input int unsigned w,
                                                   input logic [7:0]  x,
                                                   input logic [6:0]  y);
    logic [ADDR_W-1:0] xa;
    logic [ADDR_W-1:0] ya;
    xa = ADDR_W'(x);
    ya = ADDR_W'(y);
    if (w == 32'd160) return (ya << 7) + (ya << 5) + xa;
    else              return (ya * ADDR_W'(w)) + xa;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: generic synchronous FIFO, DEPTH entries of WIDTH bits.
// Ports: clk/rst, push_i/push_data_i, pop_i/pop_data_o (head, valid when
// !empty_o), full_o, empty_o, count_o (occupancy). Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module plot_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (count_o == (AW+1)'(DEPTH));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/plot_writer.sv
// plot_writer: clips pixel plot requests, linearises them to framebuffer
// addresses, buffers them and drains them to a stallable write port.
// Ports: vga_* request in (vga_plot/in_ready handshake), fb_* write out
// (fb_we held with stable addr/data until fb_ack), busy status, and
// clip_count when PLOT_CLIP_CNT_EN is defined. Address width is plot_pkg::ADDR_W.
module plot_writer
  import plot_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        vga_x,
  input  logic [6:0]        vga_y,
  input  logic [2:0]        vga_colour,
  input  logic              vga_plot,
  output logic              in_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ack,
  output logic              busy
`ifdef PLOT_CLIP_CNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic      accept;
  logic      on_screen;
  logic      s1_vld_q;
  pix_req_t  s1_req_q;

  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic [AW:0] fifo_count;
  pix_req_t  fifo_head;

  wr_state_t state_q;
  logic      fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [2:0] fb_data_q;

  logic      avail;
  logic      take;
  logic      bypass;
  pix_req_t  head;

  assign on_screen = (32'(vga_x) < 32'(SCREEN_W)) && (32'(vga_y) < 32'(SCREEN_H));
  assign accept    = vga_plot && in_ready;

  // Ready counts the stage-1 entry as already occupying a FIFO slot, so an
  // accepted request can never find the FIFO full. Purely registered terms:
  // a pop in the current cycle does not reopen ready until the next one.
  assign in_ready = !fifo_full && !((fifo_count == (AW+1)'(DEPTH-1)) && s1_vld_q);

  // Stage 1: clip and linearise. Clipped requests are consumed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_req_q <= '0;
    end else begin
      s1_vld_q <= accept && on_screen;
      if (accept) begin
        s1_req_q.addr   <= xy_to_addr(SCREEN_W, vga_x, vga_y);
        s1_req_q.colour <= vga_colour;
      end
    end
  end

  // The stage-1 entry sits logically behind the FIFO tail. When the FIFO is
  // empty the FSM takes it directly, which gives the two-cycle best-case
  // latency and one write per cycle while fb_ack stays high.
  assign avail     = !fifo_empty || s1_vld_q;
  assign take      = avail && ((state_q == ST_IDLE) || fb_ack);
  assign fifo_pop  = take && !fifo_empty;
  assign bypass    = take && fifo_empty;
  assign fifo_push = s1_vld_q && !bypass;
  assign head      = fifo_empty ? s1_req_q : fifo_head;

  plot_fifo #(
    .WIDTH ($bits(pix_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (s1_req_q),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            fb_addr_q <= head.addr;
            fb_data_q <= head.colour;
            fb_we_q   <= 1'b1;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (fb_ack) begin
            if (take) begin
              fb_addr_q <= head.addr;
              fb_data_q <= head.colour;
            end else begin
              fb_we_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign busy    = s1_vld_q || !fifo_empty || fb_we_q;

`ifdef PLOT_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else if (accept && !on_screen && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_plot_writer.sv
// tb_plot_writer: directed table of single plots plus multi-cycle sequences
// (clipping, stall/backpressure, alternating ack, mid-run reset, full sweep)
// with a write scoreboard fed by an independent address model.
module tb_plot_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        fb_ack = 1'b0;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        busy;
`ifdef PLOT_CLIP_CNT_EN
  logic [15:0] clip_count;
`endif

  plot_writer dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .in_ready   (in_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ack     (fb_ack),
    .busy       (busy)
`ifdef PLOT_CLIP_CNT_EN
    ,
    .clip_count (clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  typedef struct {
    int x;
    int y;
    int c;
    int vld;
    int addr;
  } vec_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   seq = 0;

  // Every completed framebuffer write (fb_we && fb_ack at the next edge).
  always @(negedge clk) begin
    if (!rst && fb_we && fb_ack) got_q.push_back(wr_t'{fb_addr, fb_data});
  end

  function automatic int model_addr(input int x, input int y);
    return y * 160 + x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Streams on-screen pixels from seq; mode 0 ack low, 1 ack high, 2 ack toggling.
  task automatic stream(input int n, input int mode, input int max_cyc,
                        output int acc_n, output int first_block);
    logic rdy;
    int   x, y;
    acc_n = 0;
    first_block = -1;
    for (int c = 0; c < max_cyc && acc_n < n; c++) begin
      x = seq % 160;
      y = (seq / 160) % 120;
      vga_x = 8'(x);
      vga_y = 7'(y);
      vga_colour = 3'(seq % 8);
      vga_plot = 1'b1;
      fb_ack = (mode == 1) || (mode == 2 && (c % 2) == 1);
      @(negedge clk);
      rdy = in_ready;
      if (!rdy && first_block < 0) first_block = acc_n;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(wr_t'{15'(model_addr(x, y)), 3'(seq % 8)});
        seq++;
        acc_n++;
      end
    end
    vga_plot = 1'b0;
  endtask

  task automatic plot1(input int x, input int y, input int c);
    logic rdy;
    int   k;
    vga_x = 8'(x);
    vga_y = 7'(y);
    vga_colour = 3'(c);
    vga_plot = 1'b1;
    rdy = 1'b0;
    for (k = 0; k < 50 && !rdy; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
    end
    vga_plot = 1'b0;
    check("plot1_accept", rdy, 1);
    if (rdy && x < 160 && y < 120) exp_q.push_back(wr_t'{15'(model_addr(x, y)), 3'(c)});
  endtask

  task automatic drain(input string name);
    fb_ack = 1'b1;
    vga_plot = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, "_busy_end"}, busy, 0);
    check({name, "_we_end"}, fb_we, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name);
    int bad;
    bad = -1;
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    end
    check({name, "_first_bad_index"}, bad, -1);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc, blk;

    tbl[0] = '{5,   3,   5, 1, 485};
    tbl[1] = '{0,   0,   1, 1, 0};
    tbl[2] = '{159, 119, 7, 1, 19199};
    tbl[3] = '{159, 0,   2, 1, 159};
    tbl[4] = '{0,   119, 6, 1, 19040};
    tbl[5] = '{160, 0,   3, 0, 0};
    tbl[6] = '{0,   120, 4, 0, 0};
    tbl[7] = '{255, 127, 7, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", fb_we, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fb_we_rel", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef PLOT_CLIP_CNT_EN
    check("rst_clip_count", clip_count, 0);
`endif
    @(posedge clk);
    #1;

    // Single plots: latency of exactly two cycles, address and clipping
    fb_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vga_x = 8'(tbl[i].x);
      vga_y = 7'(tbl[i].y);
      vga_colour = 3'(tbl[i].c);
      vga_plot = 1'b1;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), in_ready, 1);
      @(posedge clk);
      #1;
      vga_plot = 1'b0;
      if (tbl[i].vld != 0) exp_q.push_back(wr_t'{15'(tbl[i].addr), 3'(tbl[i].c)});
      @(negedge clk);
      check($sformatf("tbl%0d_we_n1", i), fb_we, 0);
      @(negedge clk);
      check($sformatf("tbl%0d_we_n2", i), fb_we, tbl[i].vld);
      if (tbl[i].vld != 0) begin
        check($sformatf("tbl%0d_addr", i), fb_addr, tbl[i].addr);
        check($sformatf("tbl%0d_data", i), fb_data, tbl[i].c);
      end
      repeat (3) @(posedge clk);
      #1;
    end
    drain("tbl");
    compare("tbl");

    // Clipped requests interleaved with valid ones, back to back
    do_reset();
    fb_ack = 1'b1;
    plot1(10, 10, 1);
    plot1(160, 0, 2);
    plot1(11, 10, 3);
    plot1(0, 120, 4);
    plot1(12, 10, 5);
    drain("clip");
    compare("clip");
`ifdef PLOT_CLIP_CNT_EN
    check("clip_count", clip_count, 2);
`endif

    // Stall: fb_ack low for 20 cycles while plotting every cycle
    stream(1000, 0, 20, acc, blk);
    check("stall_accepted", acc, 9);
    check("stall_block_after", blk, 9);
    fb_ack = 1'b1;
    @(negedge clk);
    check("stall_ready_registered", in_ready, 0);
    check("stall_busy", busy, 1);
    @(posedge clk);
    #1;
    drain("stall");
    compare("stall");

    // Full FIFO with fb_ack toggling while pushing continues
    stream(1000, 0, 15, acc, blk);
    check("alt_fill_blocked", blk, 9);
    stream(40, 2, 400, acc, blk);
    check("alt_accepted", acc, 40);
    drain("alt");
    compare("alt");

    // Reset with entries buffered and a write pending
    stream(6, 0, 50, acc, blk);
    repeat (2) @(posedge clk);
    #1;
    check("mid_pre_we", fb_we, 1);
    check("mid_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fb_ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_post_writes", got_q.size(), 0);
    check("mid_post_we", fb_we, 0);

    // Fill-screen sweep in raster order
    seq = 0;
    stream(19200, 1, 25000, acc, blk);
    check("sweep_accepted", acc, 19200);
    drain("sweep");
    if (got_q.size() > 0) check("sweep_last_addr", got_q[got_q.size()-1].addr, 19199);
    else check("sweep_last_addr", 32'hFFFF_FFFF, 19199);
    compare("sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
